// File: rtl/mem_ctrl.sv
// mem_ctrl: MEM-stage load/store controller that stalls the pipeline while a single
// data-bus access runs, then returns extended load data or an exception pulse.
module mem_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  opcode_in,
   input  logic [2:0]  funct3_in,
   input  logic [4:0]  rd_addr_in,
   input  logic [31:0] rs2_data_in,
   input  logic [31:0] ram_addr_in,
   output logic        stall_out,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        ld_valid_out,
   output logic [4:0]  ld_rd_addr_out,
   output logic [31:0] ld_data_out,
   output logic        misalign_out,
   output logic        bus_err_out
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        req_q, req_d, we_q, we_d, ldv_q, ldv_d, mis_q, mis_d, err_q, err_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
   logic [3:0]  be_q, be_d;
   logic [4:0]  rd_q, rd_d, ldrd_q, ldrd_d;
   logic [1:0]  off_q, off_d;
   logic [2:0]  f3_q, f3_d;
   logic        is_ld, is_st, mem_op, f3_ok, misal;
   logic [31:0] lane, ext;

   assign is_ld  = opcode_in == 7'b0000011;
   assign is_st  = opcode_in == 7'b0100011;
   assign mem_op = is_ld | is_st;
   // loads allow 000,001,010,100,101; stores allow 000,001,010
   assign f3_ok  = is_st ? (!funct3_in[2] && funct3_in[1:0] != 2'b11)
                         : (funct3_in != 3'b011 && funct3_in[2:1] != 2'b11);
   assign misal  = !f3_ok || (funct3_in[1:0] == 2'b01 && ram_addr_in[0]) ||
                   (funct3_in[1:0] == 2'b10 && |ram_addr_in[1:0]);
   assign lane   = bus_rdata >> {off_q, 3'b000};
   assign ext    = f3_q[1] ? bus_rdata :
                   f3_q[0] ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} :
                             {{24{~f3_q[2] & lane[7]}}, lane[7:0]};

   assign stall_out      = (state_q == IDLE && mem_op) || state_q == ACCESS;
   assign bus_req        = req_q;
   assign bus_we         = we_q;
   assign bus_addr       = addr_q;
   assign bus_be         = be_q;
   assign bus_wdata      = wdata_q;
   assign ld_valid_out   = ldv_q;
   assign ld_rd_addr_out = ldrd_q;
   assign ld_data_out    = ld_q;
   assign misalign_out   = mis_q;
   assign bus_err_out    = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      req_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      be_d    = '0;
      wdata_d = '0;
      rd_d    = rd_q;
      off_d   = off_q;
      f3_d    = f3_q;
      ldv_d   = 1'b0;
      ld_d    = ld_q;
      ldrd_d  = ldrd_q;
      mis_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: if (mem_op) begin
            if (misal) begin
               mis_d   = 1'b1;
               state_d = DONE;
            end else begin
               state_d = ACCESS;
               req_d   = 1'b1;
               we_d    = is_st;
               addr_d  = {ram_addr_in[31:2], 2'b00};
               be_d    = funct3_in[1] ? 4'b1111 :
                         funct3_in[0] ? 4'b0011 << ram_addr_in[1:0] : 4'b0001 << ram_addr_in[1:0];
               wdata_d = funct3_in[1] ? rs2_data_in :
                         funct3_in[0] ? {2{rs2_data_in[15:0]}} : {4{rs2_data_in[7:0]}};
               rd_d    = rd_addr_in;
               off_d   = ram_addr_in[1:0];
               f3_d    = funct3_in;
            end
         end
         ACCESS: if (bus_ack) begin
            state_d = DONE;
            if (!we_q) begin
               ldv_d  = 1'b1;
               ld_d   = ext;
               ldrd_d = rd_q;
            end
         end else if (cnt_q == 8'(TIMEOUT - 1)) begin
            state_d = DONE;
            err_d   = 1'b1;
         end else begin
            cnt_d   = cnt_q + 8'd1;
            req_d   = 1'b1;
            we_d    = we_q;
            addr_d  = addr_q;
            be_d    = be_q;
            wdata_d = wdata_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         ldv_q   <= 1'b0;
         ld_q    <= '0;
         ldrd_q  <= '0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         ldv_q   <= ldv_d;
         ld_q    <= ld_d;
         ldrd_q  <= ldrd_d;
         mis_q   <= mis_d;
         err_q   <= err_d;
      end
   end
endmodule
